// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension divide path: op encodings,
// FSM state codes, special-case result constants and a negate helper.
package muldiv_pkg;

  // funct3[1:0] encodings of the divide group
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // FSM state encoding, kept as plain constants for legacy tools
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // RISC-V mandated results for x/0 and the INT_MIN/-1 overflow case
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Two's-complement negate when n is set; INT_MIN maps to itself,
  // which read as unsigned is exactly its magnitude.
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_unit_if.sv
// Request/response bundle between issue logic, the divide unit and writeback.
interface muldiv_div_unit_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  // Issue/writeback side
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  // Divide unit side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/muldiv_div_unit_divider.sv
// Unsigned iterative 32-bit restoring long divider. One quotient bit per
// cycle: operands load on the start edge, 32 iterations follow, and valid
// rises together with the final iteration. No reset; start always wins
// over an operation in flight, so an abandoned divide is simply restarted.
module divider (
  input  logic        clk,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        valid,
  output logic        dbz,
  output logic        busy
);
  logic [31:0] q_q, r_q, y_q;
  logic [4:0]  cnt_q;
  logic        busy_q, valid_q;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        fits;

  // Shift next dividend bit into the partial remainder and trial-subtract.
  // When fits, the true difference is below 2^32, so 32 bits suffice.
  assign rem_sh = {r_q, q_q[31]};
  assign fits   = rem_sh >= {1'b0, y_q};
  assign diff   = rem_sh[31:0] - y_q;

  // Load on start, otherwise iterate while busy
  // NOTE: pure datapath registers carry no reset; start fully initialises them.
  always_ff @(posedge clk) begin
    if (start) begin
      q_q     <= x;
      r_q     <= '0;
      y_q     <= y;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      r_q   <= fits ? diff : rem_sh[31:0];
      q_q   <= {q_q[30:0], fits};
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign q     = q_q;
  assign r     = r_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign dbz   = (y_q == 32'd0);
endmodule

// File: rtl/muldiv_div_unit.sv
// RISC-V DIV/DIVU/REM/REMU front/back end around the unsigned divider.
// Divide-by-zero and INT_MIN/-1 resolve in one cycle; everything else runs
// magnitudes through the divider and sign-corrects the result.
// Optional: define DIV_RESULT_CACHE_EN to keep the last normal result so a
// following request on the same operands and signedness completes in one cycle.
module muldiv_div_unit
  import muldiv_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_div_unit_if.slave  bus
);
  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             is_rem_q, neg_q_q, neg_r_q;
  logic [31:0]      mag_a_q, mag_b_q;

  // Request decode, valid only while a request is presented in IDLE
  logic        accept, req_sgn, req_rem, b_zero, ovf;
  logic [31:0] mag_a, mag_b, special_data, q_fix, r_fix;
  logic        cache_hit;
  logic [31:0] cache_data;

  logic [31:0] div_q, div_r;
  logic        div_valid, div_start, div_dbz_unused, div_busy_unused;

  assign accept       = bus.req_valid && (state_q == ST_IDLE);
  assign req_sgn      = ~bus.req_op[0];
  assign req_rem      = bus.req_op[1];
  assign mag_a        = neg_if(req_sgn && bus.req_a[31], bus.req_a);
  assign mag_b        = neg_if(req_sgn && bus.req_b[31], bus.req_b);
  assign b_zero       = (bus.req_b == 32'd0);
  assign ovf          = req_sgn && (bus.req_a == INT_MIN) && (bus.req_b == 32'hFFFF_FFFF);
  assign special_data = b_zero ? (req_rem ? bus.req_a : DIV_ZERO_Q)
                               : (req_rem ? 32'd0     : INT_MIN);
  assign q_fix        = neg_if(neg_q_q, div_q);
  assign r_fix        = neg_if(neg_r_q, div_r);
  assign div_start    = (state_q == ST_START);

  divider u_div (
    .clk   (clk),
    .start (div_start),
    .x     (mag_a_q),
    .y     (mag_b_q),
    .q     (div_q),
    .r     (div_r),
    .valid (div_valid),
    .dbz   (div_dbz_unused),
    .busy  (div_busy_unused)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic        c_valid_q, c_sgn_q, raw_sgn_q;
  logic [31:0] c_a_q, c_b_q, c_qv_q, c_rv_q, raw_a_q, raw_b_q;

  assign cache_hit  = c_valid_q && (c_a_q == bus.req_a) && (c_b_q == bus.req_b)
                      && (c_sgn_q == req_sgn);
  assign cache_data = req_rem ? c_rv_q : c_qv_q;

  // Cache entry validity: cleared by reset, set by each normal completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   c_valid_q <= 1'b0;
    else if ((state_q == ST_WAIT) && div_valid) c_valid_q <= 1'b1;
  end

  // Raw operands captured at accept, copied into the cache at completion
  always_ff @(posedge clk) begin
    if (accept) begin
      raw_a_q   <= bus.req_a;
      raw_b_q   <= bus.req_b;
      raw_sgn_q <= req_sgn;
    end
    if ((state_q == ST_WAIT) && div_valid) begin
      c_a_q   <= raw_a_q;
      c_b_q   <= raw_b_q;
      c_sgn_q <= raw_sgn_q;
      c_qv_q  <= q_fix;
      c_rv_q  <= r_fix;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 32'd0;
`endif

  // Operand magnitudes and sign-correction flags captured at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_a_q  <= mag_a;
      mag_b_q  <= mag_b;
      is_rem_q <= req_rem;
      neg_q_q  <= req_sgn && (bus.req_a[31] ^ bus.req_b[31]);
      neg_r_q  <= req_sgn && bus.req_a[31];
    end
  end

  // Next-state and response logic
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tag_d = bus.req_tag;
          if (b_zero || ovf) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            data_d  = special_data;
          end else if (cache_hit) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            data_d  = cache_data;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (div_valid) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          data_d  = is_rem_q ? r_fix : q_fix;
        end
      end
      ST_DONE: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = valid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_tag   = tag_q;
endmodule

// File: tb/tb_muldiv_div_unit.sv
// Directed bench for muldiv_div_unit: table of DIV/REM vectors with
// hand-computed results and latencies, plus backpressure and reset sequences.
// Latency is counted as the number of clock edges after the accepting edge
// at which resp_valid first reads high: 0 for one-cycle results, 34 normal.
module tb_muldiv_div_unit;
  import muldiv_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_div_unit_if #(.TAG_W(5)) bus ();

  muldiv_div_unit #(.TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int starts = 0;

  // Count divider start pulses seen at clock edges
  always @(posedge clk) if (dut.u_div.start) starts++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request, wait for the accepting edge, then count edges to resp_valid
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int lat);
    int guard;
    @(negedge clk);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
    bit          hit;   // same operands/signedness as the previous normal divide
  } vec_t;

  vec_t vecs[15];

  initial begin
    int lat, exp_lat, s0;
    logic [31:0] d0;
    logic [4:0]  t0;

    vecs[0]  = '{"div_100_7",     OP_DIV,  32'd100,        32'd7,          5'd3,  32'd14,         34, 1'b0};
    vecs[1]  = '{"remu_100_7",    OP_REMU, 32'd100,        32'd7,          5'd17, 32'd2,          34, 1'b0};
    vecs[2]  = '{"rem_m7_2",      OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFF,  34, 1'b0};
    vecs[3]  = '{"div_m7_2",      OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  34, 1'b1};
    vecs[4]  = '{"divu_5_0",      OP_DIVU, 32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF,  0,  1'b0};
    vecs[5]  = '{"rem_x_0",       OP_REM,  32'h1234_5678,  32'd0,          5'd8,  32'h1234_5678,  0,  1'b0};
    vecs[6]  = '{"div_ovf",       OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  0,  1'b0};
    vecs[7]  = '{"rem_ovf",       OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          0,  1'b0};
    vecs[8]  = '{"divu_max_1",    OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd11, 32'hFFFF_FFFF,  34, 1'b0};
    vecs[9]  = '{"remu_min_3",    OP_REMU, 32'h8000_0000,  32'd3,          5'd12, 32'd2,          34, 1'b0};
    vecs[10] = '{"div_min_2",     OP_DIV,  32'h8000_0000,  32'd2,          5'd13, 32'hC000_0000,  34, 1'b0};
    vecs[11] = '{"rem_7_m2",      OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd14, 32'd1,          34, 1'b0};
    vecs[12] = '{"div_7_m2",      OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd15, 32'hFFFF_FFFD,  34, 1'b1};
    vecs[13] = '{"div_1000_3",    OP_DIV,  32'd1000,       32'd3,          5'd20, 32'd333,        34, 1'b0};
    vecs[14] = '{"rem_1000_3",    OP_REM,  32'd1000,       32'd3,          5'd21, 32'd1,          34, 1'b1};

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;

    // Reset values while reset is held
    #1;
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data",  bus.resp_data,       32'd0);
    check("rst_resp_tag",   32'(bus.resp_tag),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      exp_lat = (CACHE && vecs[i].hit) ? 0 : vecs[i].lat;
      s0 = starts;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, lat);
      check({vecs[i].name, "_data"},   bus.resp_data,        vecs[i].exp);
      check({vecs[i].name, "_tag"},    32'(bus.resp_tag),    32'(vecs[i].tag));
      check({vecs[i].name, "_lat"},    32'(lat),             32'(exp_lat));
      check({vecs[i].name, "_starts"}, 32'(starts - s0),     (exp_lat == 34) ? 32'd1 : 32'd0);
      consume();
      check({vecs[i].name, "_release"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    end

    // Same operands as the cached signed divide but unsigned: always a full divide
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd22, lat);
    check("divu_1000_3_data", bus.resp_data, 32'd333);
    check("divu_1000_3_lat",  32'(lat),      32'd34);
    consume();

    // Backpressure: result held stable and no new request accepted
    issue(OP_DIVU, 32'd12345, 32'd100, 5'd25, lat);
    check("hold_first_data", bus.resp_data, 32'd123);
    d0 = bus.resp_data;
    t0 = bus.resp_tag;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_data",  bus.resp_data,       d0);
      check("hold_tag",   32'(bus.resp_tag),   32'(t0));
      check("hold_ready", 32'(bus.req_ready),  32'd0);
    end
    consume();

    // Reset in the middle of a divide, then a fresh divide
    @(negedge clk);
    bus.req_op    = OP_DIV;
    bus.req_a     = 32'd50;
    bus.req_b     = 32'd5;
    bus.req_tag   = 5'd30;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_resp_data",  bus.resp_data,       32'd0);
    check("mid_rst_resp_tag",   32'(bus.resp_tag),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_DIV, 32'd1000, 32'd10, 5'd4, lat);
    check("post_rst_data", bus.resp_data,      32'd100);
    check("post_rst_tag",  32'(bus.resp_tag),  32'd4);
    check("post_rst_lat",  32'(lat),           32'd34);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_div_unit.md
Name: muldiv_div_unit

Overview:
- RISC-V M-extension divide front/back end. Sits between the execute-stage issue logic and the unsigned iterative 32-bit long divider `divider`, which it instantiates.
- Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally. Otherwise converts operands to magnitudes, runs the divider, and sign-corrects the result.
- Returns a tagged 32-bit result to writeback over a valid/ready handshake.

Parameters:
TAG_W, 5, width of request/response tag (destination register index)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
req_a  in  32  dividend (rs1)
req_b  in  32  divisor (rs2)
req_tag  in  TAG_W  opaque tag, returned with result
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  32  quotient or remainder
resp_tag  out  TAG_W  tag of the request

Behaviour:
- Reset is asynchronous and active-high.
  - Outputs during/after reset: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_tag=0.
- States: IDLE, START, WAIT, DONE.
- req_ready = (state==IDLE). Accept on edge E0 with req_valid&&req_ready. At E0:
  - Latch op, tag, a, b.
  - signed = ~op[0]; is_rem = op[1].
  - Magnitudes: |a| and |b| when signed, raw values otherwise. 0x80000000 maps to unsigned 0x80000000.
  - neg_q = signed & (a[31]^b[31]); neg_r = signed & a[31].
- Special cases, resolved at E0; go straight to DONE with resp_valid high after E0 (latency 1):
  - b==0: quotient 0xFFFFFFFF, remainder a (all four ops).
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Otherwise IDLE->START:
  - START drives divider start=1 for exactly one cycle, x=|a|, y=|b|. START->WAIT at E1.
  - WAIT samples divider valid. The divider clears valid on start, so no stale valid is seen.
  - When valid is sampled high at E34:
    - resp_data = is_rem ? (neg_r ? -r : r) : (neg_q ? -q : q), 32-bit two's complement.
    - Go to DONE.
  - Normal latency: resp_valid high 34 cycles after the acceptance edge.
- DONE:
  - Hold resp_valid, resp_data, resp_tag stable until resp_valid&&resp_ready.
  - On that edge: resp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle.
- Divider start is asserted only in START. The divider dbz output is unused because zero divisors never reach it.
- Reset mid-operation: wrapper returns to IDLE immediately. The divider (no reset) may keep iterating; its output is ignored. The next START restarts it, because start has priority over busy.
- resp_ready may be held low indefinitely; no result is lost or overwritten.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- With the macro:
  - On every normal completion, store {valid, a, b, signed, q_fixed, r_fixed}.
  - A new request with equal a, b and signedness hits the cache and goes to DONE at E0 (latency 1) with the selected result. Example: DIV followed by REM on the same operands.
  - Cache is cleared by rst.
  - Special cases never update it.
- Without the macro: no cache storage; every non-special request takes 34 cycles.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding constants OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - State enum.
  - Constants DIV_ZERO_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One sub-module instance: the existing `divider`. Sign/magnitude and correction logic stay inline.

Test Plan:
- DIV a=100, b=7 -> resp_data=14 with resp_tag echoed; resp_valid exactly 34 cycles after acceptance. REMU same operands -> 2.
- REM a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFF. DIV same operands -> 0xFFFFFFFD.
- DIVU a=5, b=0 -> 0xFFFFFFFF. REM a=0x12345678, b=0 -> 0x12345678. Both latency 1; divider start never asserted.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM same operands -> 0; latency 1.
- resp_ready held low 20 cycles after a result -> resp_valid/data/tag stable, req_ready=0. rst asserted 10 cycles into a DIV -> outputs at reset values; the next DIV 1000/10 returns 100 after 34 cycles.
- With DIV_RESULT_CACHE_EN: DIV 1000/3 (34 cycles) then REM 1000/3 -> 1 after 1 cycle. Then DIVU 1000/3 -> cache miss, 34 cycles.
